// File: rtl/pixel_ctrl_pkg.sv
// Shared types and constants for the pixel-array controller.
package pixel_ctrl_pkg;

  localparam int DATA_W            = 8;
  localparam int DEF_ERASE_CYCLES  = 5;
  localparam int DEF_EXPOSE_CYCLES = 255;
  localparam int DEF_READ_SETTLE   = 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ERASE   = 3'd1,
    S_EXPOSE  = 3'd2,
    S_CONVERT = 3'd3,
    S_READ1   = 3'd4,
    S_READ2   = 3'd5
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pixel_ramp_counter.sv
// Saturating ramp counter used during CONVERT; it holds at full scale
// rather than wrapping, so the last value stays on the bus until release.
module pixel_ramp_counter
  import pixel_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] count_o,
  output logic              tc_o
);

  localparam logic [DATA_W-1:0] CNT_ZERO = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] CNT_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] CNT_FULL = {DATA_W{1'b1}};

  logic [DATA_W-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= CNT_ZERO;
    end else if (clr_i) begin
      count_q <= CNT_ZERO;
    end else if (en_i && (count_q != CNT_FULL)) begin
      count_q <= count_q + CNT_ONE;
    end else begin
      count_q <= count_q;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == CNT_FULL);

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for the pixel array: erase, expose, ramp conversion and
// two handshaked row reads. All controls are registered alongside the state.
module pixel_array_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int C_ERASE_CYCLES  = DEF_ERASE_CYCLES,
  parameter int C_EXPOSE_CYCLES = DEF_EXPOSE_CYCLES,
  parameter int C_READ_SETTLE   = DEF_READ_SETTLE
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                START,
  output logic                ERASE,
  output logic                EXPOSE,
  output logic                READ1,
  output logic                READ2,
  output logic                RESET,
  output logic                RAMP,
  inout  wire  [DATA_W-1:0]   DATA1,
  inout  wire  [DATA_W-1:0]   DATA2,
  inout  wire  [DATA_W-1:0]   DATA3,
  inout  wire  [DATA_W-1:0]   DATA4,
  output logic                ROW_VALID,
  input  logic                ROW_READY,
  output logic                ROW_SEL,
  output logic [2*DATA_W-1:0] ROW_DATA,
  output logic                BUSY,
  output logic                FRAME_DONE
);

  localparam int CNT_MAX = max3(C_ERASE_CYCLES, C_EXPOSE_CYCLES, C_READ_SETTLE);
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ERASE_LAST  = CW'(C_ERASE_CYCLES - 1);
  localparam logic [CW-1:0] EXPOSE_LAST = CW'(C_EXPOSE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(C_READ_SETTLE - 1);

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic                erase_q, expose_q, read1_q, read2_q, reset_q, ramp_q;
  logic                row_valid_q, row_sel_q, busy_q, frame_done_q;
  logic [2*DATA_W-1:0] row_data_q;
  logic [DATA_W-1:0]   ramp_cnt_s;
  logic                ramp_tc_s;

  pixel_ramp_counter u_ramp (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .en_i    (ramp_q),
    .clr_i   (~ramp_q),
    .count_o (ramp_cnt_s),
    .tc_o    (ramp_tc_s)
  );

  // Bus drive follows the registered RAMP flag, so release coincides with leaving CONVERT.
  assign DATA1 = ramp_q ? ramp_cnt_s : {DATA_W{1'bz}};
  assign DATA2 = ramp_q ? ramp_cnt_s : {DATA_W{1'bz}};
  assign DATA3 = ramp_q ? ramp_cnt_s : {DATA_W{1'bz}};
  assign DATA4 = ramp_q ? ramp_cnt_s : {DATA_W{1'bz}};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      cnt_q        <= CNT_ZERO;
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      read1_q      <= 1'b0;
      read2_q      <= 1'b0;
      reset_q      <= 1'b0;
      ramp_q       <= 1'b0;
      row_valid_q  <= 1'b0;
      row_sel_q    <= 1'b0;
      row_data_q   <= {(2*DATA_W){1'b0}};
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          frame_done_q <= 1'b0;
          // The FRAME_DONE cycle is the first IDLE cycle; a START there is dropped.
          if (START && !frame_done_q) begin
            state_q <= S_ERASE;
            cnt_q   <= CNT_ZERO;
            erase_q <= 1'b1;
            reset_q <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            cnt_q <= CNT_ZERO;
          end
        end
        S_ERASE: begin
          reset_q <= 1'b0;
          if (cnt_q == ERASE_LAST) begin
            state_q  <= S_EXPOSE;
            cnt_q    <= CNT_ZERO;
            erase_q  <= 1'b0;
            expose_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_EXPOSE: begin
          if (cnt_q == EXPOSE_LAST) begin
            state_q  <= S_CONVERT;
            cnt_q    <= CNT_ZERO;
            expose_q <= 1'b0;
            ramp_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_CONVERT: begin
          if (ramp_tc_s) begin
            state_q <= S_READ1;
            cnt_q   <= CNT_ZERO;
            ramp_q  <= 1'b0;
            read1_q <= 1'b1;
          end else begin
            cnt_q <= CNT_ZERO;
          end
        end
        S_READ1: begin
          if (row_valid_q) begin
            if (ROW_READY) begin
              state_q     <= S_READ2;
              cnt_q       <= CNT_ZERO;
              row_valid_q <= 1'b0;
              read1_q     <= 1'b0;
              read2_q     <= 1'b1;
            end else begin
              row_valid_q <= 1'b1;
            end
          end else if (cnt_q == SETTLE_LAST) begin
            row_data_q  <= {DATA2, DATA1};
            row_sel_q   <= 1'b0;
            row_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_READ2: begin
          if (row_valid_q) begin
            if (ROW_READY) begin
              state_q      <= S_IDLE;
              cnt_q        <= CNT_ZERO;
              row_valid_q  <= 1'b0;
              read2_q      <= 1'b0;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
            end else begin
              row_valid_q <= 1'b1;
            end
          end else if (cnt_q == SETTLE_LAST) begin
            row_data_q  <= {DATA4, DATA3};
            row_sel_q   <= 1'b1;
            row_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          cnt_q        <= CNT_ZERO;
          erase_q      <= 1'b0;
          expose_q     <= 1'b0;
          read1_q      <= 1'b0;
          read2_q      <= 1'b0;
          reset_q      <= 1'b0;
          ramp_q       <= 1'b0;
          row_valid_q  <= 1'b0;
          busy_q       <= 1'b0;
          frame_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign ERASE      = erase_q;
  assign EXPOSE     = expose_q;
  assign READ1      = read1_q;
  assign READ2      = read2_q;
  assign RESET      = reset_q;
  assign RAMP       = ramp_q;
  assign ROW_VALID  = row_valid_q;
  assign ROW_SEL    = row_sel_q;
  assign ROW_DATA   = row_data_q;
  assign BUSY       = busy_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Directed bench for pixel_array_ctrl: nominal frame, row stall, ignored
// STARTs and an asynchronous reset in the middle of CONVERT.
module tb_pixel_array_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic        START = 1'b0;
  logic        ROW_READY = 1'b1;
  logic        ERASE, EXPOSE, READ1, READ2, RESET, RAMP;
  logic        ROW_VALID, ROW_SEL, BUSY, FRAME_DONE;
  logic [15:0] ROW_DATA;
  wire  [7:0]  DATA1, DATA2, DATA3, DATA4;

  logic        probe_en = 1'b0;
  logic [7:0]  pix1 = 8'h11, pix2 = 8'h11, pix3 = 8'h11, pix4 = 8'h11;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n;
  int          bad;
  int          frame_start;

  pixel_array_ctrl #(
    .C_ERASE_CYCLES  (5),
    .C_EXPOSE_CYCLES (10),
    .C_READ_SETTLE   (2)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .START      (START),
    .ERASE      (ERASE),
    .EXPOSE     (EXPOSE),
    .READ1      (READ1),
    .READ2      (READ2),
    .RESET      (RESET),
    .RAMP       (RAMP),
    .DATA1      (DATA1),
    .DATA2      (DATA2),
    .DATA3      (DATA3),
    .DATA4      (DATA4),
    .ROW_VALID  (ROW_VALID),
    .ROW_READY  (ROW_READY),
    .ROW_SEL    (ROW_SEL),
    .ROW_DATA   (ROW_DATA),
    .BUSY       (BUSY),
    .FRAME_DONE (FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Pixel models: each latches the ramp value it trips on, then drives it during its read phase.
  always @(posedge CLK) begin
    if (RAMP === 1'b1 && DATA1 === 8'h3C) pix1 <= DATA1;
    if (RAMP === 1'b1 && DATA2 === 8'hA5) pix2 <= DATA2;
    if (RAMP === 1'b1 && DATA3 === 8'h00) pix3 <= DATA3;
    if (RAMP === 1'b1 && DATA4 === 8'hFF) pix4 <= DATA4;
  end

  // A probe pattern stands in for the pixels to show the block has let go of the bus.
  assign DATA1 = probe_en ? 8'h5A : (READ1 ? pix1 : 8'hzz);
  assign DATA2 = probe_en ? 8'h5A : (READ1 ? pix2 : 8'hzz);
  assign DATA3 = probe_en ? 8'h5A : (READ2 ? pix3 : 8'hzz);
  assign DATA4 = probe_en ? 8'h5A : (READ2 ? pix4 : 8'hzz);

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    #2 RESET_N = 1'b0;
    probe_en = 1'b1;
    #1;
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_erase", ERASE, 1'b0);
    chk("rst_ramp", RAMP, 1'b0);
    chk("rst_row_valid", ROW_VALID, 1'b0);
    chk("rst_row_data", ROW_DATA, 16'h0000);
    chk("rst_data1_hiz", DATA1, 8'h5A);
    #19 RESET_N = 1'b1;
    probe_en = 1'b0;
    tick();

    // Nominal frame with ROW_READY held high
    START = 1'b1;
    tick();
    START = 1'b0;
    frame_start = cyc;
    chk("f1_reset_pulse", RESET, 1'b1);
    chk("f1_erase_first", ERASE, 1'b1);
    chk("f1_busy", BUSY, 1'b1);
    tick();
    chk("f1_reset_drop", RESET, 1'b0);
    n = 1;
    while (ERASE === 1'b1 && n < 1000) begin n++; tick(); end
    chk("f1_erase_len", n, 32'd5);
    n = 0;
    while (EXPOSE === 1'b1 && n < 1000) begin
      START = (n == 3);
      n++;
      tick();
    end
    START = 1'b0;
    chk("f1_expose_len", n, 32'd10);
    n = 0;
    bad = 0;
    while (RAMP === 1'b1 && n < 1000) begin
      if (DATA1 !== n[7:0] || DATA2 !== n[7:0] || DATA3 !== n[7:0] || DATA4 !== n[7:0]) bad++;
      n++;
      tick();
    end
    chk("f1_convert_len", n, 32'd256);
    chk("f1_ramp_values_bad", bad, 32'd0);
    chk("f1_read1_first", READ1, 1'b1);
    chk("f1_boundary_data1", DATA1, 8'h3C);
    chk("f1_boundary_data2", DATA2, 8'hA5);
    chk("f1_valid_early", ROW_VALID, 1'b0);
    tick();
    chk("f1_valid_settle", ROW_VALID, 1'b0);
    tick();
    chk("f1_row1_valid", ROW_VALID, 1'b1);
    chk("f1_row1_data", ROW_DATA, 16'hA53C);
    chk("f1_row1_sel", ROW_SEL, 1'b0);
    tick();
    chk("f1_read2_start", READ2, 1'b1);
    chk("f1_read1_end", READ1, 1'b0);
    chk("f1_valid_drop", ROW_VALID, 1'b0);
    tick();
    tick();
    chk("f1_row2_valid", ROW_VALID, 1'b1);
    chk("f1_row2_data", ROW_DATA, 16'hFF00);
    chk("f1_row2_sel", ROW_SEL, 1'b1);
    tick();
    chk("f1_frame_done", FRAME_DONE, 1'b1);
    chk("f1_frame_cycles", cyc - frame_start, 32'd277);
    chk("f1_busy_done", BUSY, 1'b0);
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("f1_done_pulse", FRAME_DONE, 1'b0);
    chk("f1_no_restart", ERASE, 1'b0);
    chk("f1_idle_busy", BUSY, 1'b0);

    // Stalled READ1 row: ROW_READY low for 7 valid cycles
    ROW_READY = 1'b0;
    START = 1'b1;
    tick();
    START = 1'b0;
    n = 0;
    while (ROW_VALID !== 1'b1 && n < 600) begin n++; tick(); end
    chk("f2_row1_seen", ROW_VALID, 1'b1);
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      if (ROW_VALID !== 1'b1 || ROW_DATA !== 16'hA53C || ROW_SEL !== 1'b0 ||
          READ1 !== 1'b1 || READ2 !== 1'b0) bad++;
      tick();
    end
    chk("f2_stall_stable_bad", bad, 32'd0);
    ROW_READY = 1'b1;
    chk("f2_still_valid", ROW_VALID, 1'b1);
    tick();
    chk("f2_read2_start", READ2, 1'b1);
    chk("f2_valid_drop", ROW_VALID, 1'b0);
    n = 0;
    while (FRAME_DONE !== 1'b1 && n < 50) begin n++; tick(); end
    chk("f2_read2_len", n, 32'd3);
    chk("f2_frame_done", FRAME_DONE, 1'b1);
    tick();
    tick();

    // Asynchronous reset at ramp count 100, then a full new frame
    START = 1'b1;
    tick();
    START = 1'b0;
    n = 0;
    while (!(RAMP === 1'b1 && DATA1 === 8'd100) && n < 600) begin n++; tick(); end
    chk("f3_reach_100", DATA1, 8'd100);
    #2 RESET_N = 1'b0;
    probe_en = 1'b1;
    #1;
    chk("f3_arst_ramp", RAMP, 1'b0);
    chk("f3_arst_busy", BUSY, 1'b0);
    chk("f3_arst_done", FRAME_DONE, 1'b0);
    chk("f3_arst_data1_hiz", DATA1, 8'h5A);
    chk("f3_arst_data4_hiz", DATA4, 8'h5A);
    tick();
    RESET_N = 1'b1;
    probe_en = 1'b0;
    tick();
    chk("f3_idle_after", BUSY, 1'b0);
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("f3_erase_first", ERASE, 1'b1);
    chk("f3_reset_pulse", RESET, 1'b1);
    n = 0;
    while (ERASE === 1'b1 && n < 1000) begin n++; tick(); end
    chk("f3_erase_len", n, 32'd5);
    n = 0;
    while (RAMP !== 1'b1 && n < 100) begin n++; tick(); end
    chk("f3_expose_len", n, 32'd10);
    chk("f3_ramp_restart", DATA1, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
